// File: rtl/vga_text_render_if.sv
// Memory-side bus of vga_text_render: char RAM and font ROM fetch ports.
// Both memories are synchronous with a 1-cycle read latency.
// The renderer uses the master modport; the memories use the slave modport.
interface vga_text_render_if;
  logic [11:0] char_addr;
  logic [15:0] char_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;

  modport master (output char_addr, output font_addr, input char_data, input font_data);
  modport slave  (input char_addr, input font_addr, output char_data, output font_data);
endinterface

// File: rtl/vga_text_render.sv
// vga_text_render: 80x30 text-mode pixel generator behind a 640x480 VGA timing
// generator. Five-stage pipeline: cell address, char RAM return, font address,
// font ROM return, palette lookup. Syncs and valid ride along through five flops.
// Optional blinking underline cursor: define VGA_TEXT_CURSOR_EN.
module vga_text_render #(
  parameter int unsigned COLS         = 80,
  parameter int unsigned ROWS         = 30,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [9:0]               h_cnt,
  input  logic [9:0]               v_cnt,
  input  logic                     valid,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  vga_text_render_if.master        mem,
  input  logic [6:0]               cursor_x,
  input  logic [4:0]               cursor_y,
  output logic [3:0]               vga_r,
  output logic [3:0]               vga_g,
  output logic [3:0]               vga_b,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic                     de_out
);

  // 4-bit IRGB index to 12-bit colour: set bits give A (F when bright),
  // clear bits give 0 (5 when bright).
  function automatic logic [11:0] palette(input logic [3:0] idx);
    logic [3:0] hi, lo;
    hi = idx[3] ? 4'hF : 4'hA;
    lo = idx[3] ? 4'h5 : 4'h0;
    return {idx[2] ? hi : lo, idx[1] ? hi : lo, idx[0] ? hi : lo};
  endfunction

  logic [11:0] char_addr_d, char_addr_q;
  logic [11:0] font_addr_d, font_addr_q;
  logic [2:0]  col1_d, col1_q, col2_d, col2_q, col3_d, col3_q, col4_d, col4_q;
  logic [3:0]  grow1_d, grow1_q, grow2_d, grow2_q;
  logic        inr1_d, inr1_q, inr2_d, inr2_q;
  logic [3:0]  fg3_d, fg3_q, bg3_d, bg3_q, fg4_d, fg4_q, bg4_d, bg4_q;
  logic [4:0]  vld_d, vld_q;
  logic [4:0]  hs_d, hs_q;
  logic [4:0]  vs_d, vs_q;
  logic [11:0] rgb_d, rgb_q;
  logic        pix_on;
  logic        force_fg;
  logic [3:0]  pix_idx;

`ifdef VGA_TEXT_CURSOR_EN
  localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [3:0]    cur_d, cur_q;
  logic          vs_prev_d, vs_prev_q;
  logic [CW-1:0] frame_cnt_d, frame_cnt_q;
  logic          blink_d, blink_q;

  // Cursor hit flag (cell match on underline rows) and frame/blink counter.
  always_comb begin
    cur_d[0]    = (h_cnt[9:3] == cursor_x) && (v_cnt[9:4] == {1'b0, cursor_y}) &&
                  (v_cnt[3:0] >= 4'd14);
    cur_d[3:1]  = cur_q[2:0];
    vs_prev_d   = vsync_in;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (vsync_in && !vs_prev_q) begin
      if (frame_cnt_q == CW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + CW'(1);
      end
    end
  end

  // Cursor state registers; previous vsync resets inactive so release is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_q       <= '0;
      vs_prev_q   <= 1'b1;
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      cur_q       <= cur_d;
      vs_prev_q   <= vs_prev_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign force_fg = blink_q && cur_q[3];
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_x, cursor_y, BLINK_FRAMES[0]};
  assign force_fg      = 1'b0;
`endif

  // Next-state for every pipeline stage.
  always_comb begin
    // stage 1: cell address and per-pixel position
    char_addr_d = valid ? 12'(32'(v_cnt[9:4]) * COLS + 32'(h_cnt[9:3])) : '0;
    col1_d      = h_cnt[2:0];
    grow1_d     = v_cnt[3:0];
    inr1_d      = (32'(v_cnt[9:4]) < ROWS) && (32'(h_cnt[9:3]) < COLS);
    // stage 2: wait for char RAM
    col2_d      = col1_q;
    grow2_d     = grow1_q;
    inr2_d      = inr1_q;
    // stage 3: glyph row address; off-screen cells collapse to index 0 (black)
    font_addr_d = {mem.char_data[7:0], grow2_q};
    fg3_d       = inr2_q ? mem.char_data[11:8]  : '0;
    bg3_d       = inr2_q ? mem.char_data[15:12] : '0;
    col3_d      = col2_q;
    // stage 4: wait for font ROM
    fg4_d       = fg3_q;
    bg4_d       = bg3_q;
    col4_d      = col3_q;
    // stage 5: pixel select, palette, blanking
    pix_on      = mem.font_data[3'(3'd7 - col4_q)];
    pix_idx     = (pix_on || force_fg) ? fg4_q : bg4_q;
    rgb_d       = vld_q[3] ? palette(pix_idx) : '0;
    // valid/sync delay lines: bit k is the value after stage k+1
    vld_d       = {vld_q[3:0], valid};
    hs_d        = {hs_q[3:0], hsync_in};
    vs_d        = {vs_q[3:0], vsync_in};
  end

  // Pipeline registers; sync delay lines reset high so release emits no false pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      char_addr_q <= '0;
      font_addr_q <= '0;
      col1_q      <= '0;
      col2_q      <= '0;
      col3_q      <= '0;
      col4_q      <= '0;
      grow1_q     <= '0;
      grow2_q     <= '0;
      inr1_q      <= 1'b0;
      inr2_q      <= 1'b0;
      fg3_q       <= '0;
      bg3_q       <= '0;
      fg4_q       <= '0;
      bg4_q       <= '0;
      vld_q       <= '0;
      hs_q        <= '1;
      vs_q        <= '1;
      rgb_q       <= '0;
    end else begin
      char_addr_q <= char_addr_d;
      font_addr_q <= font_addr_d;
      col1_q      <= col1_d;
      col2_q      <= col2_d;
      col3_q      <= col3_d;
      col4_q      <= col4_d;
      grow1_q     <= grow1_d;
      grow2_q     <= grow2_d;
      inr1_q      <= inr1_d;
      inr2_q      <= inr2_d;
      fg3_q       <= fg3_d;
      bg3_q       <= bg3_d;
      fg4_q       <= fg4_d;
      bg4_q       <= bg4_d;
      vld_q       <= vld_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      rgb_q       <= rgb_d;
    end
  end

  assign mem.char_addr = char_addr_q;
  assign mem.font_addr = font_addr_q;
  assign vga_r         = rgb_q[11:8];
  assign vga_g         = rgb_q[7:4];
  assign vga_b         = rgb_q[3:0];
  assign de_out        = vld_q[4];
  assign hsync_out     = hs_q[4];
  assign vsync_out     = vs_q[4];

endmodule

// File: tb/tb_vga_text_render.sv
// Bench for vga_text_render: memory models, directed probes and random pixels
// checked against a per-pixel text-mode reference model.
`timescale 1ns/1ps
module tb_vga_text_render;
  localparam int unsigned COLS = 80;
  localparam int unsigned ROWS = 30;
`ifdef VGA_TEXT_CURSOR_EN
  localparam int unsigned TB_BLINK = 2;
`else
  localparam int unsigned TB_BLINK = 30;
`endif

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       vld;
    logic       hs;
    logic       vs;
    logic [6:0] cx;
    logic [4:0] cy;
    logic       fill;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] h_cnt = '0, v_cnt = '0;
  logic       valid = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic [6:0] cursor_x = 7'd127;
  logic [4:0] cursor_y = 5'd31;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       hsync_out, vsync_out, de_out;

  logic [15:0] char_ram [0:4095];
  logic [7:0]  font_rom [0:4095];

  int   errors = 0;
  int   checks = 0;
  pix_t hist[$];
  logic [6:0] cur_cx = 7'd127;
  logic [4:0] cur_cy = 5'd31;
  int unsigned m_edges = 0;
  logic m_blink = 1'b0;
  logic m_prev_vs = 1'b1;

  vga_text_render_if mem_if();

  vga_text_render #(.COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(TB_BLINK)) dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .mem(mem_if),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out)
  );

  always #20 clk = ~clk;

  // synchronous 1-cycle-latency char RAM and font ROM
  always @(posedge clk) begin
    mem_if.char_data <= char_ram[mem_if.char_addr];
    mem_if.font_data <= font_rom[mem_if.font_addr];
  end

  function automatic logic [3:0] lvl(logic b, logic i);
    return b ? (i ? 4'hF : 4'hA) : (i ? 4'h5 : 4'h0);
  endfunction

  function automatic logic [11:0] pal(logic [3:0] x);
    return {lvl(x[2], x[3]), lvl(x[1], x[3]), lvl(x[0], x[3])};
  endfunction

  function automatic int unsigned cell_addr(pix_t p);
    if (!p.vld) return 0;
    return ((int'(p.v) / 16) * COLS + int'(p.h) / 8) % 4096;
  endfunction

  // what a text-mode screen shows at pixel p
  function automatic logic [11:0] exp_rgb(pix_t p);
    int unsigned row, col, fa;
    int px;
    logic [15:0] w;
    logic [7:0] g;
    logic [3:0] idx;
    if (!p.vld) return '0;
    row = int'(p.v) / 16;
    col = int'(p.h) / 8;
    if (row >= ROWS || col >= COLS) return '0;
    w  = char_ram[row * COLS + col];
    fa = int'(w[7:0]) * 16 + int'(p.v) % 16;
    g  = font_rom[fa];
    px = int'(p.h) % 8;
    idx = g[7 - px] ? w[11:8] : w[15:12];
`ifdef VGA_TEXT_CURSOR_EN
    if (m_blink && col == p.cx && row == p.cy && (int'(p.v) % 16) >= 14) idx = w[11:8];
`endif
    return pal(idx);
  endfunction

  function automatic pix_t mk(int h, int v, logic vld, logic hs, logic vs);
    pix_t p;
    p.h = 10'(h); p.v = 10'(v); p.vld = vld; p.hs = hs; p.vs = vs;
    p.cx = cur_cx; p.cy = cur_cy; p.fill = 1'b0;
    return p;
  endfunction

  function automatic pix_t idle();
    return mk(0, 0, 1'b0, 1'b1, 1'b1);
  endfunction

  function automatic pix_t rnd();
    return mk(int'($urandom_range(639)), int'($urandom_range(479)),
              1'($urandom_range(3) != 0), 1'($urandom_range(1)), 1'($urandom_range(1)));
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic set_in(pix_t p);
    h_cnt = p.h; v_cnt = p.v; valid = p.vld; hsync_in = p.hs; vsync_in = p.vs;
    cursor_x = p.cx; cursor_y = p.cy;
  endtask

  // empty pipeline as seen right after reset release
  task automatic fill();
    pix_t p;
    p = idle();
    p.fill = 1'b1;
    hist.delete();
    repeat (5) hist.push_back(p);
    m_edges = 0; m_blink = 1'b0; m_prev_vs = 1'b1;
    set_in(idle());
  endtask

  // one clock: check outputs against earlier inputs, then apply p
  task automatic step(pix_t p);
    pix_t e5, e3, e1;
    logic [15:0] w;
    @(posedge clk); #1;
    e5 = hist[hist.size() - 5];
    e3 = hist[hist.size() - 3];
    e1 = hist[hist.size() - 1];
    chk("rgb", {4'h0, vga_r, vga_g, vga_b}, {4'h0, exp_rgb(e5)});
    chk("de_out", 16'(de_out), 16'(e5.vld));
    chk("hsync_out", 16'(hsync_out), 16'(e5.hs));
    chk("vsync_out", 16'(vsync_out), 16'(e5.vs));
    chk("char_addr", 16'(mem_if.char_addr), 16'(cell_addr(e1)));
    if (!e3.fill) begin
      w = char_ram[cell_addr(e3)];
      chk("font_addr", 16'(mem_if.font_addr), {4'h0, w[7:0], e3.v[3:0]});
    end
    set_in(p);
    if (p.vs && !m_prev_vs) begin
      m_edges++;
      m_blink = 1'((m_edges / TB_BLINK) % 2);
    end
    m_prev_vs = p.vs;
    hist.push_back(p);
    if (hist.size() > 8) void'(hist.pop_front());
  endtask

  // single pixel followed by idles, checking address, font address and colour
  task automatic probe(pix_t p, logic [11:0] ea, logic [11:0] ef, logic [11:0] er, string tag);
    step(p);
    step(idle());
    chk({tag, "_char_addr"}, 16'(mem_if.char_addr), 16'(ea));
    step(idle());
    step(idle());
    chk({tag, "_font_addr"}, 16'(mem_if.font_addr), 16'(ef));
    step(idle());
    step(idle());
    chk({tag, "_rgb"}, {4'h0, vga_r, vga_g, vga_b}, 16'(er));
  endtask

  task automatic vs_edge();
    step(mk(0, 0, 1'b0, 1'b1, 1'b0));
    step(mk(0, 0, 1'b0, 1'b1, 1'b0));
    step(idle());
    step(idle());
  endtask

  initial begin
    int lowcnt, first;
    logic [15:0] w;
    for (int i = 0; i < 4096; i++) begin
      char_ram[i] = 16'($urandom);
      font_rom[i] = 8'($urandom);
    end
    char_ram[0]    = 16'hFFFF;
    char_ram[162]  = 16'h7141;
    font_rom[12'h413] = 8'h20;
    char_ram[2399] = 16'h3A5C;
    font_rom[12'h5CF] = 8'h01;
    char_ram[82]   = 16'h2C41;
    font_rom[12'h41D] = 8'h00;
    font_rom[12'h41E] = 8'h00;
    font_rom[12'h41F] = 8'h00;

    // reset held with clock running
    #5 rst = 1'b0;
    set_in(mk(100, 100, 1'b1, 1'b0, 1'b0));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", {4'h0, vga_r, vga_g, vga_b}, 16'h0);
    chk("rst_de", 16'(de_out), 16'h0);
    chk("rst_hs", 16'(hsync_out), 16'h1);
    chk("rst_vs", 16'(vsync_out), 16'h1);
    chk("rst_char_addr", 16'(mem_if.char_addr), 16'h0);
    chk("rst_font_addr", 16'(mem_if.font_addr), 16'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    fill();

    // random pixels
    repeat (400) step(rnd());
    repeat (6) step(idle());

    // directed cells
    probe(mk(17, 35, 1'b1, 1'b1, 1'b1), 12'd162, 12'h413, 12'hAAA, "p17_35");
    probe(mk(18, 35, 1'b1, 1'b1, 1'b1), 12'd162, 12'h413, 12'h00A, "p18_35");
    probe(mk(16, 35, 1'b1, 1'b1, 1'b1), 12'd162, 12'h413, 12'hAAA, "p16_35");
    probe(mk(639, 479, 1'b1, 1'b1, 1'b1), 12'd2399, 12'h5CF, 12'h5F5, "p639_479");
    w = char_ram[2485];
    probe(mk(40, 500, 1'b1, 1'b1, 1'b1), 12'd2485, {w[7:0], 4'h4}, 12'h000, "row_oob");

    // 96-cycle hsync pulse
    lowcnt = 0;
    first = -1;
    for (int i = 0; i < 106; i++) begin
      pix_t p;
      p = rnd();
      p.hs = (i < 96) ? 1'b0 : 1'b1;
      p.vs = 1'b1;
      step(p);
      if (hsync_out === 1'b0) begin
        lowcnt++;
        if (first < 0) first = i;
      end
    end
    chk("hsync_len", 16'(lowcnt), 16'd96);
    chk("hsync_start", 16'(first), 16'd5);

    // blanking with char RAM word FFFF at address 0
    for (int i = 0; i < 10; i++) begin
      pix_t p;
      p = rnd();
      p.vld = 1'b0;
      step(p);
    end
    chk("blank_char_addr", 16'(mem_if.char_addr), 16'h0);
    chk("blank_rgb", {4'h0, vga_r, vga_g, vga_b}, 16'h0);
    chk("blank_de", 16'(de_out), 16'h0);

    // reset mid-line with valid pixels in flight
    repeat (4) step(mk(18, 35, 1'b1, 1'b0, 1'b1));
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("mid_rgb", {4'h0, vga_r, vga_g, vga_b}, 16'h0);
    chk("mid_de", 16'(de_out), 16'h0);
    chk("mid_hs", 16'(hsync_out), 16'h1);
    chk("mid_vs", 16'(vsync_out), 16'h1);
    chk("mid_char_addr", 16'(mem_if.char_addr), 16'h0);
    chk("mid_font_addr", 16'(mem_if.font_addr), 16'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    fill();
    probe(mk(17, 35, 1'b1, 1'b1, 1'b1), 12'd162, 12'h413, 12'hAAA, "post_rst");
    repeat (20) step(rnd());
    repeat (6) step(idle());

`ifdef VGA_TEXT_CURSOR_EN
    // blinking cursor at cell (2,1)
    cur_cx = 7'd2;
    cur_cy = 5'd1;
    probe(mk(16, 30, 1'b1, 1'b1, 1'b1), 12'd82, 12'h41E, 12'h0A0, "cur_off");
    vs_edge();
    vs_edge();
    repeat (6) step(idle());
    probe(mk(16, 30, 1'b1, 1'b1, 1'b1), 12'd82, 12'h41E, 12'hF55, "cur_on14");
    probe(mk(20, 31, 1'b1, 1'b1, 1'b1), 12'd82, 12'h41F, 12'hF55, "cur_on15");
    probe(mk(16, 29, 1'b1, 1'b1, 1'b1), 12'd82, 12'h41D, 12'h0A0, "cur_row13");
    vs_edge();
    vs_edge();
    repeat (6) step(idle());
    probe(mk(16, 30, 1'b1, 1'b1, 1'b1), 12'd82, 12'h41E, 12'h0A0, "cur_off2");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_text_render.md
Name: vga_text_render

Overview:
- Text-mode pixel generator directly downstream of the VGA timing generator (640x480 @ 60 Hz, 25 MHz pixel clock).
- Consumes the timing generator's pixel coordinates, active-video flag and syncs. Fetches the character cell from an external char RAM and the glyph row from an external font ROM, both with synchronous 1-cycle read.
- Drives 12-bit RGB plus syncs, delayed so everything stays pixel-aligned.
- 80x30 cells of 8x16 pixels.

Parameters:
- COLS, 80, characters per row; char_addr row stride
- ROWS, 30, character rows; rows >= ROWS render background
- BLINK_FRAMES, 30, frames per cursor blink phase (used only with VGA_TEXT_CURSOR_EN)

Ports:
- clk  in  1  25 MHz pixel clock
- rst  in  1  asynchronous, active-low reset
- h_cnt  in  10  pixel x, 0..639 when valid
- v_cnt  in  10  pixel y, 0..479 when valid
- valid  in  1  active-video flag
- hsync_in  in  1  horizontal sync, active-low
- vsync_in  in  1  vertical sync, active-low
- char_addr  out  12  char RAM address
- char_data  in  16  [7:0] code, [11:8] fg index, [15:12] bg index; valid 1 cycle after address
- font_addr  out  12  {code[7:0], glyph_row[3:0]}
- font_data  in  8  glyph row, bit7 = leftmost pixel; valid 1 cycle after address
- cursor_x  in  7  cursor column
- cursor_y  in  5  cursor row
- vga_r, vga_g, vga_b  out  4 each  pixel colour
- hsync_out, vsync_out  out  1  delayed syncs
- de_out  out  1  delayed valid

Behaviour:
- Reset values (async on rst=0):
  - char_addr=0, font_addr=0, rgb=0, de_out=0.
  - hsync_out=1 and vsync_out=1 (sync inactive).
  - All pipeline registers 0; frame counter and blink phase 0.
- Pipeline, input sampled in cycle 0:
  - Edge 1: char_addr <= (v_cnt>>4)*COLS + (h_cnt>>3). Also register col=h_cnt[2:0], grow=v_cnt[3:0], cell coords, valid.
  - Edge 2: char_data returns.
  - Edge 3: font_addr <= {char_data[7:0], grow}. Latch fg and bg indices.
  - Edge 4: font_data returns.
  - Edge 5: rgb registered from the selected pixel.
  - Total latency is 5 cycles. hsync_in, vsync_in and valid pass through exactly 5 flops each, so they stay aligned with rgb.
- Arithmetic:
  - char_addr is computed at 12 bits with truncation; maximum in-range value is 2399.
  - When the stage-1 valid is 0, char_addr is driven 0.
- Pixel selection:
  - Pixel on = font_data[7 - col_d], where col_d is col delayed to align with font_data.
  - Colour index = on ? fg : bg.
- Palette (index bit3=I, bit2=R, bit1=G, bit0=B), per channel:
  - Channel bit set: I ? F : A.
  - Channel bit clear: I ? 5 : 0.
  - Example: index 7 gives A,A,A; index 15 gives F,F,F; index 8 gives 5,5,5.
- Blanking: when the delayed valid is 0, rgb = 0 regardless of fetched data.
- Cells beyond the screen: cell row >= ROWS or column >= COLS outputs the bg of index 0, which is black.
- The invalid-coordinate value 0x3FF on h_cnt/v_cnt is never used while valid=0.
- Reset mid-frame:
  - All outputs return to their reset values immediately.
  - After release, the first valid input pixel appears on the outputs 5 cycles later.
  - No stale data is emitted; flushed stages carry valid=0.

Optional Feature:
- Macro: VGA_TEXT_CURSOR_EN.
- Defined:
  - Frame counter increments on each vsync_in rising edge, detected with a registered previous value.
  - When the count reaches BLINK_FRAMES-1, the counter wraps to 0 and the blink phase toggles.
  - While blink phase = 1, pixels of cell (cursor_x, cursor_y) with glyph row 14 or 15 are forced to the fg colour.
  - Cursor coordinates are sampled at stage 1 and pipelined with the pixel.
- Undefined:
  - No counter and no blink logic.
  - cursor_x and cursor_y are ignored; ports remain for interface stability.
  - Output equals font rendering only.

Test Plan:
- Reset held, clock running -> rgb=0, de_out=0, hsync_out=vsync_out=1. Assert rst=0 mid-line -> same values within the same cycle.
- valid=1, h_cnt=17, v_cnt=35 -> char_addr=162 one edge later. With char_data=16'h7141 and font_data=8'h20, col=1 gives rgb=A,A,A and col=0 gives bg index 7's colour; both appear exactly 5 cycles after the input.
- Pulse hsync_in low for 96 cycles -> hsync_out low for 96 cycles, starting exactly 5 cycles later.
- valid=0 with char_data=16'hFFFF -> rgb=0, de_out=0; char_addr=0 one edge after valid=0 is sampled.
- h_cnt=639, v_cnt=479 -> char_addr=2399; font_addr={code, 4'hF}.
- With VGA_TEXT_CURSOR_EN, cursor=(2,1), BLINK_FRAMES=2 -> after 2 vsync rising edges, cell (2,1) rows 14-15 show the fg colour; after 2 more edges they show the normal glyph.
